// File: rtl/qoi_frame_packer.sv
// qoi_frame_packer: wraps each encoded QOI frame in its container. The output is the
// 14-byte header, then the chunk bytes from the encoder, then the 8-byte end marker.
// Handshake, both sides: a beat or byte moves on a rising clk edge where valid and
// ready are both 1. The valid side keeps data and flags steady until that edge.
module qoi_frame_packer #(
    parameter int IMAGE_W    = 640,
    parameter int IMAGE_H    = 480,
    parameter int CHANNELS   = 3,
    parameter int COLORSPACE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [39:0] sink_data,
    input  logic [2:0]  sink_len,
    input  logic        sink_valid,
    output logic        sink_ready,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic [7:0]  source_data,
    output logic        source_valid,
    input  logic        source_ready,
    output logic        source_sop,
    output logic        source_eop,
    output logic        frame_done,
    output logic [31:0] frame_bytes,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        CHUNK   = 2'd2,
        TRAILER = 2'd3
    } state_t;

    localparam logic [31:0] WIDTH_W  = 32'(IMAGE_W);
    localparam logic [31:0] HEIGHT_W = 32'(IMAGE_H);
    localparam logic [7:0]  CHAN_B   = 8'(CHANNELS);
    localparam logic [7:0]  CSPACE_B = 8'(COLORSPACE);

    state_t      state, state_n;
    logic [3:0]  hdr_idx, hdr_idx_n;
    logic [2:0]  trl_idx, trl_idx_n;
    logic [39:0] hold_data, hold_data_n;
    logic [2:0]  hold_len, hold_len_n;
    logic [2:0]  hold_idx, hold_idx_n;
    logic        hold_eop, hold_eop_n;
    logic        hold_valid, hold_valid_n;
    logic        pending_sop, pending_sop_n;
    logic        do_latch;
    logic [31:0] byte_cnt;

    logic        emit_valid, emit_sop, emit_eop, ready_n;
    logic [7:0]  emit_data;

    logic        accept;
    logic        beat_in;
    logic [2:0]  len_clamped;

    assign accept      = source_valid && source_ready;
    assign beat_in     = sink_valid && sink_ready;
    assign len_clamped = (sink_len > 3'd5) ? 3'd5 : sink_len;
    assign frame_done  = source_valid && source_ready && source_eop;
    assign dbg_state   = state;

    function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    hdr_byte = 8'h71;
            4'd1:    hdr_byte = 8'h6f;
            4'd2:    hdr_byte = 8'h69;
            4'd3:    hdr_byte = 8'h66;
            4'd4:    hdr_byte = WIDTH_W[31:24];
            4'd5:    hdr_byte = WIDTH_W[23:16];
            4'd6:    hdr_byte = WIDTH_W[15:8];
            4'd7:    hdr_byte = WIDTH_W[7:0];
            4'd8:    hdr_byte = HEIGHT_W[31:24];
            4'd9:    hdr_byte = HEIGHT_W[23:16];
            4'd10:   hdr_byte = HEIGHT_W[15:8];
            4'd11:   hdr_byte = HEIGHT_W[7:0];
            4'd12:   hdr_byte = CHAN_B;
            4'd13:   hdr_byte = CSPACE_B;
            default: hdr_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] chunk_byte(input logic [39:0] d, input logic [2:0] idx);
        case (idx)
            3'd0:    chunk_byte = d[39:32];
            3'd1:    chunk_byte = d[31:24];
            3'd2:    chunk_byte = d[23:16];
            3'd3:    chunk_byte = d[15:8];
            3'd4:    chunk_byte = d[7:0];
            default: chunk_byte = 8'h00;
        endcase
    endfunction

    // Next-state logic: the indices always point at the byte that is on the output now.
    // Each state moves forward only when that byte is accepted.
    always_comb begin
        state_n       = state;
        hdr_idx_n     = hdr_idx;
        trl_idx_n     = trl_idx;
        hold_data_n   = hold_data;
        hold_len_n    = hold_len;
        hold_idx_n    = hold_idx;
        hold_eop_n    = hold_eop;
        hold_valid_n  = hold_valid;
        pending_sop_n = pending_sop;
        do_latch      = 1'b0;
        case (state)
            IDLE: begin
                if (beat_in && sink_sop) begin
                    do_latch      = 1'b1;
                    pending_sop_n = 1'b0;
                    hdr_idx_n     = 4'd0;
                    state_n       = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    if (hdr_idx == 4'd13) state_n = CHUNK;
                    else                  hdr_idx_n = hdr_idx + 4'd1;
                end
            end
            CHUNK: begin
                if (hold_valid) begin
                    if (hold_len == 3'd0) begin
                        hold_valid_n = 1'b0;
                        if (hold_eop) begin
                            state_n   = TRAILER;
                            trl_idx_n = 3'd0;
                        end
                    end else if (accept) begin
                        if (hold_idx == hold_len - 3'd1) begin
                            hold_valid_n = 1'b0;
                            if (hold_eop) begin
                                state_n   = TRAILER;
                                trl_idx_n = 3'd0;
                            end
                        end else begin
                            hold_idx_n = hold_idx + 3'd1;
                        end
                    end
                end else if (beat_in) begin
                    do_latch = 1'b1;
                    // A new start-of-frame here aborts the frame in progress. The beat
                    // waits in hold and opens the next frame once this trailer is sent.
                    if (sink_sop) begin
                        pending_sop_n = 1'b1;
                        state_n       = TRAILER;
                        trl_idx_n     = 3'd0;
                    end
                end
            end
            TRAILER: begin
                if (accept) begin
                    if (trl_idx == 3'd7) begin
                        state_n       = pending_sop ? HEADER : IDLE;
                        hdr_idx_n     = 4'd0;
                        pending_sop_n = 1'b0;
                    end else begin
                        trl_idx_n = trl_idx + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (do_latch) begin
            hold_data_n  = sink_data;
            hold_len_n   = len_clamped;
            hold_eop_n   = sink_eop;
            hold_idx_n   = 3'd0;
            hold_valid_n = 1'b1;
        end
    end

    // Output selection from the next state, so the registered outputs present the byte
    // the FSM will be on in the next cycle.
    always_comb begin
        emit_valid = 1'b0;
        emit_data  = 8'h00;
        emit_sop   = 1'b0;
        emit_eop   = 1'b0;
        ready_n    = (state_n == IDLE) || (state_n == CHUNK && !hold_valid_n);
        case (state_n)
            HEADER: begin
                emit_valid = 1'b1;
                emit_data  = hdr_byte(hdr_idx_n);
                emit_sop   = (hdr_idx_n == 4'd0);
            end
            CHUNK: begin
                emit_valid = hold_valid_n && (hold_len_n != 3'd0);
                emit_data  = chunk_byte(hold_data_n, hold_idx_n);
            end
            TRAILER: begin
                emit_valid = 1'b1;
                emit_data  = {7'd0, trl_idx_n == 3'd7};
                emit_eop   = (trl_idx_n == 3'd7);
            end
            default: ;
        endcase
    end

    // State, hold, registered outputs and the per-frame byte counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            hdr_idx      <= 4'd0;
            trl_idx      <= 3'd0;
            hold_data    <= 40'd0;
            hold_len     <= 3'd0;
            hold_idx     <= 3'd0;
            hold_eop     <= 1'b0;
            hold_valid   <= 1'b0;
            pending_sop  <= 1'b0;
            source_valid <= 1'b0;
            source_data  <= 8'h00;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            sink_ready   <= 1'b0;
            byte_cnt     <= 32'd0;
            frame_bytes  <= 32'd0;
        end else begin
            state        <= state_n;
            hdr_idx      <= hdr_idx_n;
            trl_idx      <= trl_idx_n;
            hold_data    <= hold_data_n;
            hold_len     <= hold_len_n;
            hold_idx     <= hold_idx_n;
            hold_eop     <= hold_eop_n;
            hold_valid   <= hold_valid_n;
            pending_sop  <= pending_sop_n;
            source_valid <= emit_valid;
            source_data  <= emit_data;
            source_sop   <= emit_sop;
            source_eop   <= emit_eop;
            sink_ready   <= ready_n;
            if (accept) begin
                byte_cnt <= source_sop ? 32'd1 : byte_cnt + 32'd1;
                if (source_eop) frame_bytes <= byte_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_qoi_frame_packer.sv
// tb_qoi_frame_packer: random and directed chunk streams. A frame-level reference model
// supplies the expected byte stream and frame lengths.
module tb_qoi_frame_packer;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int CHANS = 3;
    localparam int CSPACE = 0;

    logic        clk;
    logic        reset_n;
    logic [39:0] sink_data;
    logic [2:0]  sink_len;
    logic        sink_valid;
    logic        sink_ready;
    logic        sink_sop;
    logic        sink_eop;
    logic [7:0]  source_data;
    logic        source_valid;
    logic        source_ready;
    logic        source_sop;
    logic        source_eop;
    logic        frame_done;
    logic [31:0] frame_bytes;
    logic [1:0]  dbg_state;

    qoi_frame_packer #(
        .IMAGE_W(IMG_W), .IMAGE_H(IMG_H), .CHANNELS(CHANS), .COLORSPACE(CSPACE)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .sink_data(sink_data), .sink_len(sink_len), .sink_valid(sink_valid),
        .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .frame_done(frame_done), .frame_bytes(frame_bytes), .dbg_state(dbg_state)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_total = 0;
    int rdy_mode = 0;

    // Scoreboard: {sop, eop, byte} per expected output byte, plus expected frame lengths.
    logic [9:0]  exp_q[$];
    logic [31:0] fb_q[$];
    bit          m_in_frame = 1'b0;
    logic [31:0] m_cnt = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model at frame level
    function automatic void push_byte(input logic [7:0] b, input bit s, input bit e);
        exp_q.push_back({s, e, b});
        m_cnt = m_cnt + 32'd1;
    endfunction

    function automatic void m_start();
        m_cnt = 32'd0;
        push_byte(8'h71, 1'b1, 1'b0);
        push_byte(8'h6f, 1'b0, 1'b0);
        push_byte(8'h69, 1'b0, 1'b0);
        push_byte(8'h66, 1'b0, 1'b0);
        for (int k = 3; k >= 0; k--) push_byte(8'((IMG_W >> (8 * k)) & 255), 1'b0, 1'b0);
        for (int k = 3; k >= 0; k--) push_byte(8'((IMG_H >> (8 * k)) & 255), 1'b0, 1'b0);
        push_byte(8'(CHANS), 1'b0, 1'b0);
        push_byte(8'(CSPACE), 1'b0, 1'b0);
        m_in_frame = 1'b1;
    endfunction

    function automatic void m_end();
        for (int k = 0; k < 7; k++) push_byte(8'h00, 1'b0, 1'b0);
        push_byte(8'h01, 1'b0, 1'b1);
        fb_q.push_back(m_cnt);
        m_in_frame = 1'b0;
    endfunction

    function automatic void model_beat(input logic [39:0] d, input logic [2:0] l,
                                       input bit s, input bit e);
        int n;
        n = (l > 3'd5) ? 5 : int'(l);
        if (!m_in_frame && !s) return;
        if (m_in_frame && s) m_end();
        if (s) m_start();
        for (int i = 0; i < n; i++) push_byte(d[39 - 8 * i -: 8], 1'b0, 1'b0);
        if (e) m_end();
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        fb_q.delete();
        m_in_frame = 1'b0;
    endfunction

    function automatic logic [39:0] rand40();
        return {8'($urandom), $urandom};
    endfunction

    // Driver: present one beat and hold it until the packer takes it
    task automatic send_beat(input logic [39:0] d, input logic [2:0] l, input bit s, input bit e);
        int waited;
        waited = 0;
        model_beat(d, l, s, e);
        sink_data  = d;
        sink_len   = l;
        sink_sop   = s;
        sink_eop   = e;
        sink_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sink_ready) break;
            waited++;
            if (waited > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL sink_timeout: sink_ready stayed 0, expected 1 within 2000 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_data  = rand40();
    endtask

    task automatic send_t1_frame();
        send_beat(40'hC5_DEADBEEF, 3'd1, 1'b1, 1'b0);
        send_beat(40'h8A77_123456, 3'd2, 1'b0, 1'b0);
        send_beat(40'hFE102030_99, 3'd4, 1'b0, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fb_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0 || fb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d bytes and %0d lengths outstanding, expected 0",
                     exp_q.size(), fb_q.size());
        end
    endtask

    // Downstream ready: always 1, or a random coin per cycle
    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            source_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: stall stability, byte order, frame_done and frame_bytes
    logic        mon_stalled = 1'b0;
    logic [9:0]  mon_held = 10'd0;
    logic        mon_fb_pend = 1'b0;
    logic [31:0] mon_fb_exp = 32'd0;
    logic [9:0]  mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_stalled = 1'b0;
                mon_fb_pend = 1'b0;
                continue;
            end
            if (mon_fb_pend) begin
                chk("frame_bytes", frame_bytes, mon_fb_exp);
                mon_fb_pend = 1'b0;
            end
            if (mon_stalled) begin
                chk("stall_valid", 32'(source_valid), 32'd1);
                chk("stall_hold", 32'({source_sop, source_eop, source_data}), 32'(mon_held));
            end
            mon_stalled = source_valid && !source_ready;
            mon_held    = {source_sop, source_eop, source_data};
            if (source_valid && source_ready) begin
                acc_total++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h, expected no output", source_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_byte", 32'({source_sop, source_eop, source_data}), 32'(mon_e));
                    chk("frame_done", 32'(frame_done), 32'(mon_e[8]));
                    if (mon_e[8]) begin
                        if (fb_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL frame_len_queue: got end marker, expected none");
                        end else begin
                            mon_fb_exp  = fb_q.pop_front();
                            mon_fb_pend = 1'b1;
                        end
                    end
                end
            end else if (frame_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_done_spurious: got 1, expected 0");
            end
        end
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit hit, expected completion");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int base;
        int w;
        reset_n    = 1'b0;
        sink_data  = 40'd0;
        sink_len   = 3'd0;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_source_valid", 32'(source_valid), 32'd0);
        chk("rst_source_data", 32'(source_data), 32'd0);
        chk("rst_source_sop", 32'(source_sop), 32'd0);
        chk("rst_source_eop", 32'(source_eop), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_bytes", frame_bytes, 32'd0);
        chk("rst_sink_ready", 32'(sink_ready), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;

        // Single frame, no backpressure
        rdy_mode = 0;
        send_t1_frame();
        drain(2000);

        // Same frame under random backpressure
        rdy_mode = 1;
        send_t1_frame();
        drain(4000);

        // Junk beats in IDLE, then a frame
        rdy_mode = 0;
        send_beat(40'h1122334455, 3'd3, 1'b0, 1'b0);
        send_beat(40'h6677889900, 3'd5, 1'b0, 1'b1);
        send_beat(40'hAABBCCDDEE, 3'd0, 1'b0, 1'b0);
        send_t1_frame();
        drain(2000);

        // Empty beats mid-frame, oversize length, empty eop beat
        send_beat(40'h1122000000, 3'd2, 1'b1, 1'b0);
        send_beat(40'hFFFFFFFFFF, 3'd0, 1'b0, 1'b0);
        send_beat(40'h0102030405, 3'd7, 1'b0, 1'b0);
        send_beat(40'h3344550000, 3'd3, 1'b0, 1'b0);
        send_beat(40'hEEEEEEEEEE, 3'd0, 1'b0, 1'b1);
        drain(2000);

        // Abort by a mid-frame start-of-frame
        rdy_mode = 1;
        send_beat(40'hAABB000000, 3'd2, 1'b1, 1'b0);
        send_beat(40'hCC00000000, 3'd1, 1'b0, 1'b0);
        send_beat(40'h00FFFFFFFF, 3'd1, 1'b1, 1'b0);
        send_beat(40'h5A5B000000, 3'd2, 1'b0, 1'b0);
        send_beat(40'h7E00000000, 3'd1, 1'b0, 1'b1);
        drain(4000);

        // Reset in the middle of the header
        rdy_mode = 0;
        base = acc_total;
        send_beat(40'h4200000000, 3'd1, 1'b1, 1'b0);
        w = 0;
        while (acc_total < base + 6 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("hdr_progress", 32'(acc_total >= base + 6), 32'd1);
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("mid_rst_source_valid", 32'(source_valid), 32'd0);
        chk("mid_rst_source_data", 32'(source_data), 32'd0);
        chk("mid_rst_source_sop", 32'(source_sop), 32'd0);
        chk("mid_rst_source_eop", 32'(source_eop), 32'd0);
        chk("mid_rst_frame_bytes", frame_bytes, 32'd0);
        chk("mid_rst_sink_ready", 32'(sink_ready), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_sink_ready", 32'(sink_ready), 32'd1);
        chk("post_rst_state", 32'(dbg_state), 32'd0);
        send_t1_frame();
        drain(2000);

        // Random frames with junk, random lengths, aborts and backpressure
        rdy_mode = 1;
        for (int f = 0; f < 30; f++) begin
            int nb;
            if ($urandom_range(0, 3) == 0)
                send_beat(rand40(), 3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)));
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                bit s;
                s = (b == 0) || ($urandom_range(0, 7) == 0);
                send_beat(rand40(), 3'($urandom_range(0, 7)), s, b == nb - 1);
            end
        end
        drain(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qoi_frame_packer.md
Name: qoi_frame_packer

Overview:
- Sequencer downstream of the QOI encoder. It wraps each encoded frame in a QOI container: 14-byte header, then the packed chunk bytes, then the 8-byte end marker.
- Accepts variable-length encoder chunks (0–5 bytes each) on an Avalon-ST-style sink and serialises them onto an 8-bit byte stream for the SDRAM/UART writer.
- Owns all framing decisions: frame start, frame end, aborted frames, and the per-frame byte count.

Parameters:
- IMAGE_W, 640: header width field, 32-bit big-endian.
- IMAGE_H, 480: header height field, 32-bit big-endian.
- CHANNELS, 3: header channels byte.
- COLORSPACE, 0: header colorspace byte.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- sink_data  in  40  chunk bytes; byte0 = [39:32], byte4 = [7:0]
- sink_len  in  3  valid byte count, 0..5; values 6..7 are treated as 5
- sink_valid  in  1  chunk beat valid
- sink_ready  out  1  packer can accept a beat
- sink_sop  in  1  first chunk of frame
- sink_eop  in  1  last chunk of frame
- source_data  out  8  output byte
- source_valid  out  1  byte valid
- source_ready  in  1  downstream accepts byte
- source_sop  out  1  first header byte (0x71)
- source_eop  out  1  last end-marker byte (0x01)
- frame_done  out  1  one-cycle pulse on the cycle the final 0x01 byte is accepted
- frame_bytes  out  32  total bytes of the last completed frame, header and marker included

Behaviour:
- Reset values: sink_ready=0, source_valid=0, source_data=0, source_sop=0, source_eop=0, frame_done=0, frame_bytes=0. The hold register is emptied and the FSM goes to IDLE. Reset mid-frame drops all partial output with no trailer.
- Hold register: holds one chunk (data, len, eop flag, byte index 0..4, hold_valid).
- sink_ready is 1 when state is IDLE, or when state is CHUNK and hold_valid=0. It is 0 in HEADER and TRAILER.
- Source outputs are registered. source_data, source_sop and source_eop stay stable while source_valid=1 and source_ready=0. An output byte is consumed only when source_valid and source_ready are both 1.
- State IDLE:
  - A beat with sink_sop=0 is accepted and discarded.
  - A beat with sink_sop=1 is latched into hold; go to HEADER with header index 0. The first header byte is valid on the next cycle (latency 1).
- State HEADER: emits 14 bytes in this order:
  - 0x71 0x6f 0x69 0x66
  - IMAGE_W[31:24..7:0]
  - IMAGE_H[31:24..7:0]
  - CHANNELS
  - COLORSPACE
  - source_sop=1 on byte 0 only. After byte 13 is accepted, go to CHUNK.
- State CHUNK:
  - If hold is valid with len>0, emit hold bytes byte0 through byte(len-1), one per accepted cycle.
  - On acceptance of the last byte, clear hold_valid.
  - If the held eop flag is set, go to TRAILER instead.
  - A held beat with len=0 produces no output. It is cleared in the cycle after latch, or goes to TRAILER if its eop is set.
  - Back-to-back operation: while the last byte of a chunk is being accepted, sink_ready is still 0. A new beat is accepted in the next cycle, so there is a 1-cycle bubble per chunk, which is permitted.
- Mid-frame sink_sop: a sink_sop=1 beat accepted in CHUNK is an implicit abort. It is latched with pending_sop=1, the FSM goes to TRAILER, and after the trailer goes directly to HEADER rather than IDLE. Its chunk bytes are then emitted as the first chunk of the new frame.
- A beat with both sink_sop=1 and sink_eop=1 forms a complete one-chunk frame.
- State TRAILER: emits 0x00 ×7 then 0x01, with source_eop=1 on 0x01. When that byte is accepted:
  - pulse frame_done;
  - load frame_bytes with the running count;
  - go to HEADER if pending_sop, otherwise to IDLE.
- Byte counter: 32-bit, cleared when source_sop is accepted, incremented on every accepted byte. Wraps modulo 2^32; no saturation.
- Simultaneous events: the source handshake and the FSM transition are evaluated in the same cycle. frame_done and the next header's byte 0 becoming valid may occur in back-to-back cycles.

Test Plan:
1. Single frame with defaults. Send beats sop+len=1 (0xC5), len=2 (0x8A,0x77), eop+len=4 (0xFE,0x10,0x20,0x30); source_ready=1.
   - Required bytes: 71 6f 69 66 00 00 02 80 00 00 01 e0 03 00 C5 8A 77 FE 10 20 30, then 00×7 01.
   - frame_bytes=29; frame_done pulses once.
2. Backpressure: same stimulus with source_ready toggled randomly (50%) → identical byte sequence; no byte changes while valid=1 and ready=0.
3. Junk before frame: three beats without sop in IDLE → all accepted (sink_ready=1) and no output. The following sop frame is emitted as in test 1.
4. len=0 beats mid-frame plus an eop beat with len=0 → no data bytes for those beats; trailer follows the last non-empty chunk directly.
5. Abort: in CHUNK send a sop+len=1 (0x00) beat → current frame gets its trailer, frame_done pulses, then header 71 6f… begins without returning to IDLE. The new frame's first data byte is 0x00.
6. Reset asserted mid-header (after byte 5) → next cycle all outputs are 0 and state is IDLE; a new sop frame restarts at 0x71 with frame_bytes reporting only that frame.
